avmm_ccip_wr_rsp_tracker: RTL and testbench
===========================================

// Module: avmm_ccip_wr_rsp_tracker
// PURPOSE
//  Downstream companion of the host-write bridge: consumes the CCI-P c1 TX request beats the bridge issues
//  and the c1 RX write/fence responses that come back, tracking outstanding write lines and fences.
//  Generates a credit stall for the bridge, a write-complete pulse, and a drain handshake.
//  The DMA IRQ path uses the drain handshake so an interrupt never overtakes its data.
// PARAMETERS
//  MAX_OUTSTANDING  512  max write lines in flight; the counter must never exceed it
//  STALL_MARGIN     8    credit_stall asserts when outstanding_lines >= MAX_OUTSTANDING-STALL_MARGIN
//  CNT_W            10   width of outstanding_lines; must be >= $clog2(MAX_OUTSTANDING+1)
// PORTS
//  clk               in   1      host clock (afu_clk domain); only clock
//  reset             in   1      synchronous, active-high
//  c1tx_valid        in   1      one c1 TX beat issued this cycle
//  c1tx_is_fence     in   1      beat is a WrFence (qualified by c1tx_valid)
//  c1rx_valid        in   1      c1 RX response this cycle
//  c1rx_is_fence     in   1      response is a fence response
//  c1rx_format       in   1      1 = packed write response
//  c1rx_cl_num       in   2      packed: lines covered = cl_num+1; ignored when unpacked
//  drain_req         in   1      level; request a drain to zero outstanding
//  outstanding_lines out  CNT_W  write lines in flight (registered)
//  fences_pending    out  4      fences in flight (saturating, registered)
//  credit_stall      out  1      bridge must hold further c1 TX beats
//  wr_done           out  1      1-cycle pulse: all writes and fences retired
//  drain_ack         out  1      level; drain complete, held while drain_req=1
//  err_underflow     out  1      sticky; a response arrived with nothing outstanding
// BEHAVIOUR
//  Reset: every output is 0. State is IDLE. Counters are cleared.
//  Reset mid-operation discards all in-flight accounting with no pulse.
//  Line count, per cycle: next = cur + inc - dec.
//   inc = 1 for a write beat (c1tx_valid & !c1tx_is_fence).
//   dec = unpacked write rsp ? 1 : packed ? cl_num+1 : 0.
//  Same-cycle inc and dec apply net. Example: cur=0, inc=1, dec=1 -> stays 0 with no error.
//  Underflow (dec > cur+inc): clamp to 0 and set err_underflow. err_underflow clears only on reset.
//  Fence count: +1 on c1tx fence, -1 on c1rx fence response.
//   Saturates at 15; clamps at 0, setting err_underflow on underflow.
//  credit_stall is registered from next-state and is visible 1 cycle after the beat that crosses the threshold.
//   The bridge may issue at most 1 beat in the cycle stall rises; STALL_MARGIN absorbs this.
//   A beat arriving at outstanding==MAX_OUTSTANDING is counted (clamped at MAX) and sets err_underflow.
//   It is the only overflow case.
//  FSM states IDLE, BUSY, DRAIN, ACK.
//   IDLE->BUSY: any tx beat.
//   BUSY->IDLE: next lines==0 and next fences==0. wr_done=1 for that one cycle (registered with the transition).
//   IDLE/BUSY->DRAIN: drain_req=1. drain_req has priority over BUSY->IDLE in the same cycle.
//   DRAIN->ACK: counters both 0. drain_ack=1 from the cycle after entry into ACK. wr_done pulses once on the transition.
//   ACK->IDLE: drain_req=0; drain_ack drops the same cycle the state leaves ACK.
//   In DRAIN, credit_stall is forced to 1. Beats that still arrive are counted; they are not dropped.
//   drain_req deasserted while in DRAIN -> return to BUSY (or IDLE if empty) with no ack.
//   In IDLE with drain_req=1 and empty -> DRAIN for 1 cycle, then ACK.
// STRUCTURE
//  Add to ccip_avmm_pkg: the state enum t_wr_trk_state and the localparam CCIP_WR_MAX_PACKED_LINES=4.
//  One natural sub-module: sat_updown_counter #(W, MAX), net add/sub with clamp plus an underflow flag.
//  The top instantiates it twice (lines, fences) plus the FSM; ~200 lines total.
// TESTING
//  1. Reset then 4 write beats, then 1 packed rsp cl_num=3 -> count 1,2,3,4 then 0; wr_done pulses once; err=0.
//  2. Same-cycle tx beat and unpacked rsp at count=5 -> count stays 5; no wr_done.
//  3. Issue 504 beats with MAX=512, MARGIN=8 -> credit_stall=1 the cycle after the 504th.
//     Retire 1 line -> stall drops the next cycle.
//  4. 2 writes + fence, drain_req=1 -> stall forced.
//     Rsps for the writes, then the fence -> drain_ack 1 cycle after the fence rsp.
//     drain_req=0 -> drain_ack=0 and state IDLE.
//  5. Unpacked rsp with count=0 -> count stays 0 and err_underflow=1.
//     The error persists through later traffic and clears only on reset.
//  6. Reset asserted with count=37 and fences=2 -> all outputs 0 next cycle, no wr_done pulse, state IDLE.

Source files
------------

// File: rtl/ccip_avmm_pkg.sv
// Shared CCI-P / Avalon-MM bridge types: write-response tracker state and packed-response limits.
package ccip_avmm_pkg;

   typedef enum logic [1:0] {
      WR_TRK_IDLE  = 2'd0,
      WR_TRK_BUSY  = 2'd1,
      WR_TRK_DRAIN = 2'd2,
      WR_TRK_ACK   = 2'd3
   } t_wr_trk_state;

   localparam int CCIP_WR_MAX_PACKED_LINES = 4;

   // Lines retired by one c1 RX beat: packed responses cover cl_num+1 lines.
   function automatic logic [2:0] wr_rsp_lines(input logic       valid,
                                               input logic       is_fence,
                                               input logic       format,
                                               input logic [1:0] cl_num);
      logic [2:0] n;
      n = 3'd0;
      if (valid && !is_fence)
         n = format ? ({1'b0, cl_num} + 3'd1) : 3'd1;
      return n;
   endfunction

endpackage

// File: rtl/avmm_ccip_wr_rsp_tracker_sat_updown_counter.sv
// Registered up/down counter applying a net increment/decrement per cycle, clamped to [0, MAX].
module sat_updown_counter #(
   parameter int   W          = 10,
   parameter int   MAX        = 512,
   parameter int   DW         = 3,
   parameter logic ERR_ON_OVF = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] inc,
   input  logic [DW-1:0] dec,
   output logic [W-1:0]  count,
   output logic [W-1:0]  count_next,
   output logic          err
);
   localparam int SW = W + 1;

   logic [SW-1:0] sum;
   logic          underflow;
   logic          overflow;

   always_comb begin
      sum        = {1'b0, count} + SW'(inc);
      underflow  = 1'b0;
      overflow   = 1'b0;
      count_next = count;
      if (SW'(dec) > sum) begin
         underflow  = 1'b1;
         count_next = '0;
      end else if ((sum - SW'(dec)) > SW'(MAX)) begin
         overflow   = 1'b1;
         count_next = W'(MAX);
      end else begin
         count_next = W'(sum - SW'(dec));
      end
   end

   assign err = underflow | (overflow & ERR_ON_OVF);

   always_ff @(posedge clk) begin
      if (reset) count <= '0;
      else       count <= count_next;
   end
endmodule

// File: rtl/avmm_ccip_wr_rsp_tracker.sv
// Tracks outstanding c1 write lines and fences; drives credit stall, write-complete and drain handshake.
// state | meaning
// IDLE  | nothing tracked, no drain requested
// BUSY  | writes or fences in flight
// DRAIN | drain requested, waiting for counters to reach zero (stall forced)
// ACK   | drained, drain_ack held until drain_req drops
module avmm_ccip_wr_rsp_tracker
   import ccip_avmm_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 512,
   parameter int STALL_MARGIN    = 8,
   parameter int CNT_W           = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             c1tx_valid,
   input  logic             c1tx_is_fence,
   input  logic             c1rx_valid,
   input  logic             c1rx_is_fence,
   input  logic             c1rx_format,
   input  logic [1:0]       c1rx_cl_num,
   input  logic             drain_req,
   output logic [CNT_W-1:0] outstanding_lines,
   output logic [3:0]       fences_pending,
   output logic             credit_stall,
   output logic             wr_done,
   output logic             drain_ack,
   output logic             err_underflow
);
   localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(MAX_OUTSTANDING - STALL_MARGIN);

   t_wr_trk_state    state_q, next_state;
   logic [CNT_W-1:0] lines_next;
   logic [3:0]       fences_next;
   logic             lines_err, fences_err, next_empty;
   logic             wr_done_d, stall_d;
   logic             wr_done_q, stall_q, err_q;

   sat_updown_counter #(.W(CNT_W), .MAX(MAX_OUTSTANDING), .DW(3), .ERR_ON_OVF(1'b1)) u_lines (
      .clk        (clk),
      .reset      (reset),
      .inc        ({2'b00, c1tx_valid & ~c1tx_is_fence}),
      .dec        (wr_rsp_lines(c1rx_valid, c1rx_is_fence, c1rx_format, c1rx_cl_num)),
      .count      (outstanding_lines),
      .count_next (lines_next),
      .err        (lines_err)
   );

   // Fences saturate silently at 15; only underflow is an error.
   sat_updown_counter #(.W(4), .MAX(15), .DW(1), .ERR_ON_OVF(1'b0)) u_fences (
      .clk        (clk),
      .reset      (reset),
      .inc        (c1tx_valid & c1tx_is_fence),
      .dec        (c1rx_valid & c1rx_is_fence),
      .count      (fences_pending),
      .count_next (fences_next),
      .err        (fences_err)
   );

   assign next_empty = (lines_next == '0) && (fences_next == 4'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= WR_TRK_IDLE;
         wr_done_q <= 1'b0;
         stall_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= next_state;
         wr_done_q <= wr_done_d;
         stall_q   <= stall_d;
         err_q     <= err_q | lines_err | fences_err;
      end
   end

   always_comb begin
      next_state = state_q;
      case (state_q)
         WR_TRK_IDLE:
            if (drain_req)                     next_state = WR_TRK_DRAIN;
            else if (c1tx_valid || !next_empty) next_state = WR_TRK_BUSY;
         WR_TRK_BUSY:
            if (drain_req)       next_state = WR_TRK_DRAIN;
            else if (next_empty) next_state = WR_TRK_IDLE;
         WR_TRK_DRAIN:
            if (!drain_req)      next_state = next_empty ? WR_TRK_IDLE : WR_TRK_BUSY;
            else if (next_empty) next_state = WR_TRK_ACK;
         WR_TRK_ACK:
            if (!drain_req)      next_state = WR_TRK_IDLE;
         default:                next_state = WR_TRK_IDLE;
      endcase
   end

   always_comb begin
      wr_done_d = ((state_q == WR_TRK_BUSY)  && (next_state == WR_TRK_IDLE)) ||
                  ((state_q == WR_TRK_DRAIN) && (next_state == WR_TRK_ACK));
      stall_d   = (lines_next >= STALL_TH) || (next_state == WR_TRK_DRAIN);
   end

   assign credit_stall  = stall_q;
   assign wr_done       = wr_done_q;
   assign drain_ack     = (state_q == WR_TRK_ACK);
   assign err_underflow = err_q;
endmodule

// File: tb/tb_avmm_ccip_wr_rsp_tracker.sv
// Directed bench for the c1 write-response tracker with hand-computed expectations.
module tb_avmm_ccip_wr_rsp_tracker;
   import ccip_avmm_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       c1tx_valid, c1tx_is_fence;
   logic       c1rx_valid, c1rx_is_fence, c1rx_format;
   logic [1:0] c1rx_cl_num;
   logic       drain_req;
   logic [9:0] outstanding_lines;
   logic [3:0] fences_pending;
   logic       credit_stall, wr_done, drain_ack, err_underflow;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   avmm_ccip_wr_rsp_tracker #(.MAX_OUTSTANDING(512), .STALL_MARGIN(8), .CNT_W(10)) dut (
      .clk               (clk),
      .reset             (reset),
      .c1tx_valid        (c1tx_valid),
      .c1tx_is_fence     (c1tx_is_fence),
      .c1rx_valid        (c1rx_valid),
      .c1rx_is_fence     (c1rx_is_fence),
      .c1rx_format       (c1rx_format),
      .c1rx_cl_num       (c1rx_cl_num),
      .drain_req         (drain_req),
      .outstanding_lines (outstanding_lines),
      .fences_pending    (fences_pending),
      .credit_stall      (credit_stall),
      .wr_done           (wr_done),
      .drain_ack         (drain_ack),
      .err_underflow     (err_underflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic clear_in();
      c1tx_valid = 0; c1tx_is_fence = 0;
      c1rx_valid = 0; c1rx_is_fence = 0; c1rx_format = 0; c1rx_cl_num = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clear_in();
   endtask

   task automatic do_reset();
      reset = 1; clear_in();
      tick();
      reset = 0;
   endtask

   task automatic beat(input logic fence);
      c1tx_valid = 1; c1tx_is_fence = fence;
      tick();
   endtask

   task automatic rsp(input logic fence, input logic fmt, input logic [1:0] cl);
      c1rx_valid = 1; c1rx_is_fence = fence; c1rx_format = fmt; c1rx_cl_num = cl;
      tick();
   endtask

   function automatic logic [31:0] st();
      return 32'(dut.state_q);
   endfunction

   initial begin
      reset = 1; drain_req = 0; clear_in();
      tick(); tick();
      check("rst_lines", 32'(outstanding_lines), 0);
      check("rst_fences", 32'(fences_pending), 0);
      check("rst_outs", {credit_stall, wr_done, drain_ack, err_underflow}, 0);
      check("rst_state", st(), 32'(WR_TRK_IDLE));
      reset = 0;

      // 1: four beats, one packed response retiring all four
      for (int i = 1; i <= 4; i++) begin
         beat(0);
         check("t1_count", 32'(outstanding_lines), 32'(i));
         check("t1_nodone", 32'(wr_done), 0);
      end
      rsp(0, 1, 2'd3);
      check("t1_zero", 32'(outstanding_lines), 0);
      check("t1_done", 32'(wr_done), 1);
      tick();
      check("t1_done_once", 32'(wr_done), 0);
      check("t1_idle", st(), 32'(WR_TRK_IDLE));
      check("t1_err", 32'(err_underflow), 0);

      // 2: same-cycle beat and unpacked response
      do_reset();
      for (int i = 0; i < 5; i++) beat(0);
      check("t2_five", 32'(outstanding_lines), 5);
      c1tx_valid = 1; c1rx_valid = 1;
      tick();
      check("t2_net", 32'(outstanding_lines), 5);
      check("t2_nodone", 32'(wr_done), 0);
      check("t2_err", 32'(err_underflow), 0);

      // 3: stall threshold and overflow clamp
      do_reset();
      for (int i = 0; i < 503; i++) beat(0);
      check("t3_503_stall", 32'(credit_stall), 0);
      beat(0);
      check("t3_504_count", 32'(outstanding_lines), 504);
      check("t3_504_stall", 32'(credit_stall), 1);
      rsp(0, 0, 2'd0);
      check("t3_retire_count", 32'(outstanding_lines), 503);
      check("t3_retire_stall", 32'(credit_stall), 0);
      for (int i = 0; i < 9; i++) beat(0);
      check("t3_max", 32'(outstanding_lines), 512);
      check("t3_max_err", 32'(err_underflow), 0);
      beat(0);
      check("t3_ovf_clamp", 32'(outstanding_lines), 512);
      check("t3_ovf_err", 32'(err_underflow), 1);

      // 4: drain with writes and a fence in flight
      do_reset();
      beat(0); beat(0); beat(1);
      check("t4_lines", 32'(outstanding_lines), 2);
      check("t4_fences", 32'(fences_pending), 1);
      drain_req = 1;
      tick();
      check("t4_drain_state", st(), 32'(WR_TRK_DRAIN));
      check("t4_stall", 32'(credit_stall), 1);
      rsp(0, 0, 2'd0);
      rsp(0, 0, 2'd0);
      check("t4_lines0", 32'(outstanding_lines), 0);
      check("t4_stall_hold", 32'(credit_stall), 1);
      check("t4_noack", 32'(drain_ack), 0);
      rsp(1, 0, 2'd0);
      check("t4_fences0", 32'(fences_pending), 0);
      check("t4_ack", 32'(drain_ack), 1);
      check("t4_done", 32'(wr_done), 1);
      tick();
      check("t4_ack_hold", 32'(drain_ack), 1);
      check("t4_done_once", 32'(wr_done), 0);
      drain_req = 0;
      tick();
      check("t4_ack_drop", 32'(drain_ack), 0);
      check("t4_idle", st(), 32'(WR_TRK_IDLE));
      drain_req = 1;
      tick();
      check("t4_empty_drain", st(), 32'(WR_TRK_DRAIN));
      check("t4_empty_noack", 32'(drain_ack), 0);
      tick();
      check("t4_empty_ack", 32'(drain_ack), 1);
      drain_req = 0;
      tick();

      // 5: sticky underflow
      do_reset();
      rsp(0, 0, 2'd0);
      check("t5_count", 32'(outstanding_lines), 0);
      check("t5_err", 32'(err_underflow), 1);
      beat(0); beat(0);
      check("t5_count2", 32'(outstanding_lines), 2);
      rsp(0, 1, 2'd1);
      check("t5_count0", 32'(outstanding_lines), 0);
      check("t5_err_sticky", 32'(err_underflow), 1);
      do_reset();
      check("t5_err_clr", 32'(err_underflow), 0);

      // 6: reset mid-operation
      for (int i = 0; i < 37; i++) beat(0);
      beat(1); beat(1);
      check("t6_lines", 32'(outstanding_lines), 37);
      check("t6_fences", 32'(fences_pending), 2);
      reset = 1;
      tick();
      check("t6_lines0", 32'(outstanding_lines), 0);
      check("t6_fences0", 32'(fences_pending), 0);
      check("t6_outs", {credit_stall, wr_done, drain_ack, err_underflow}, 0);
      check("t6_state", st(), 32'(WR_TRK_IDLE));
      reset = 0;
      tick();
      check("t6_nodone", 32'(wr_done), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end
endmodule
